// File: rtl/i2c_burst_controller.sv
// Open-drain I2C master for register transactions carrying a 0..MAX_BURST byte burst
// (slave auto-increment), with streamed write data and strobed read data.
// Ports: clk_i/rst_i (sync, active-high); address_i/rw_i/register_id_i/length_i/execute_i
//   command; wr_data_i/wr_ready_o write stream; rd_data_o/rd_valid_o read stream;
//   busy_o/done_o/nack_o status; scl_o/sda_io open-drain bus (drive 0 or release to Z).
module i2c_burst_controller #(
  parameter  int CLK_DIV   = 4,
  parameter  int MAX_BURST = 16,
  localparam int LEN_W     = $clog2(MAX_BURST + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [6:0]       address_i,
  input  logic             rw_i,
  input  logic [7:0]       register_id_i,
  input  logic [LEN_W-1:0] length_i,
  input  logic             execute_i,
  input  logic [7:0]       wr_data_i,
  output logic             wr_ready_o,
  output logic [7:0]       rd_data_o,
  output logic             rd_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             nack_o,
  output logic             scl_o,
  inout  wire              sda_io
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK, S_WDATA, S_WDATA_ACK,
    S_RSTART, S_RADDR, S_RADDR_ACK, S_RDATA, S_RDATA_ACK, S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       q_q;        // quarter-phase within the current bit
  logic [2:0]       bit_q;      // bit index within a byte state, MSB first
  logic [7:0]       sh_q;       // transmit shift register
  logic [7:0]       rx_q;       // receive shift register
  logic             samp_q;     // SDA captured on the first cycle of Q3
  logic [LEN_W-1:0] rem_q;      // data bytes still to transfer
  logic [6:0]       addr_q;
  logic             rw_q;
  logic [7:0]       reg_q;
  logic             nack_q, done_q, rd_valid_q;
  logic [7:0]       rd_data_q;

  logic             scl_low, sda_low, wr_ready;
  logic             sda_in, tick, bit_end, last_bit, sample_now, sda_s, ack_s;
  logic [LEN_W-1:0] len_clamped;

  assign sda_in      = sda_io;
  assign tick        = (div_q == DIV_W'(CLK_DIV - 1));
  assign bit_end     = tick && (q_q == 2'd3);
  assign last_bit    = (bit_q == 3'd7);
  assign sample_now  = (q_q == 2'd3) && (div_q == '0);
  // With CLK_DIV=1 the sample cycle is also the bit-end cycle, so bypass the register.
  assign sda_s       = sample_now ? sda_in : samp_q;
  assign ack_s       = ~sda_s;
  assign len_clamped = (length_i > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : length_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (execute_i) state_d = S_START;
      S_START:     if (bit_end) state_d = S_ADDR;
      S_ADDR:      if (bit_end && last_bit) state_d = S_ADDR_ACK;
      S_ADDR_ACK:  if (bit_end) state_d = ack_s ? S_REG : S_STOP;
      S_REG:       if (bit_end && last_bit) state_d = S_REG_ACK;
      S_REG_ACK: begin
        if (bit_end) begin
          if (!ack_s || rem_q == '0) state_d = S_STOP;
          else if (rw_q)             state_d = S_RSTART;
          else                       state_d = S_WDATA;
        end
      end
      S_WDATA:     if (bit_end && last_bit) state_d = S_WDATA_ACK;
      S_WDATA_ACK: if (bit_end) state_d = (!ack_s || rem_q == '0) ? S_STOP : S_WDATA;
      S_RSTART:    if (bit_end) state_d = S_RADDR;
      S_RADDR:     if (bit_end && last_bit) state_d = S_RADDR_ACK;
      S_RADDR_ACK: if (bit_end) state_d = ack_s ? S_RDATA : S_STOP;
      S_RDATA:     if (bit_end && last_bit) state_d = S_RDATA_ACK;
      S_RDATA_ACK: if (bit_end) state_d = (rem_q == '0) ? S_STOP : S_RDATA;
      S_STOP:      if (bit_end) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output decode: line drive per state and quarter-phase
  always_comb begin
    scl_low  = 1'b0;
    sda_low  = 1'b0;
    wr_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        scl_low = 1'b0;
      end
      S_START: begin
        sda_low = q_q[1];
      end
      S_ADDR, S_REG, S_RADDR: begin
        scl_low = ~q_q[1];
        sda_low = ~sh_q[7];
      end
      S_WDATA: begin
        scl_low  = ~q_q[1];
        wr_ready = (bit_q == 3'd0) && (q_q == 2'd0) && (div_q == '0);
        // The byte is only captured at the end of the pop cycle, so the MSB comes straight from the input.
        sda_low  = wr_ready ? ~wr_data_i[7] : ~sh_q[7];
      end
      S_RDATA_ACK: begin
        scl_low = ~q_q[1];
        sda_low = (rem_q != '0);  // ACK all but the final byte
      end
      S_RSTART: begin
        scl_low = (q_q == 2'd0);
        sda_low = q_q[1];
      end
      S_STOP: begin
        scl_low = ~q_q[1];
        sda_low = (q_q != 2'd3);
      end
      default: begin
        scl_low = ~q_q[1];  // slave-driven bits: ACK slots and read data
      end
    endcase
  end

  // Datapath: bit timing, shifting, command latch, status
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q      <= '0;
      q_q        <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      rx_q       <= '0;
      samp_q     <= 1'b1;
      rem_q      <= '0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      reg_q      <= '0;
      nack_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      done_q     <= (state_q == S_STOP) && bit_end;
      rd_valid_q <= 1'b0;

      if (state_q == S_IDLE) begin
        div_q <= '0;
        q_q   <= '0;
        bit_q <= '0;
        if (execute_i) begin
          addr_q <= address_i;
          rw_q   <= rw_i;
          reg_q  <= register_id_i;
          rem_q  <= len_clamped;
          nack_q <= 1'b0;
        end
      end else begin
        if (tick) begin
          div_q <= '0;
          q_q   <= q_q + 2'd1;
        end else begin
          div_q <= div_q + DIV_W'(1);
        end
        if (bit_end) bit_q <= (state_d != state_q) ? 3'd0 : bit_q + 3'd1;
      end

      if (sample_now) samp_q <= sda_in;

      if (wr_ready) begin
        sh_q <= wr_data_i;
      end else if (bit_end) begin
        case (state_q)
          S_START:                        sh_q <= {addr_q, 1'b0};
          S_ADDR_ACK:                     sh_q <= reg_q;
          S_RSTART:                       sh_q <= {addr_q, 1'b1};
          S_ADDR, S_REG, S_WDATA, S_RADDR: sh_q <= {sh_q[6:0], 1'b0};
          default:                        sh_q <= sh_q;
        endcase
      end

      if (sample_now && state_q == S_RDATA) begin
        rx_q <= {rx_q[6:0], sda_in};
        if (last_bit) begin
          rd_data_q  <= {rx_q[6:0], sda_in};
          rd_valid_q <= 1'b1;
        end
      end

      if (bit_end && last_bit && (state_q == S_WDATA || state_q == S_RDATA))
        rem_q <= rem_q - LEN_W'(1);

      if (bit_end && sda_s &&
          (state_q == S_ADDR_ACK || state_q == S_REG_ACK ||
           state_q == S_WDATA_ACK || state_q == S_RADDR_ACK))
        nack_q <= 1'b1;
    end
  end

  assign wr_ready_o = wr_ready;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = done_q;
  assign nack_o     = nack_q;
  assign scl_o      = scl_low ? 1'b0 : 1'bz;
  assign sda_io     = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_burst_controller.sv
module tb_i2c_burst_controller;
  localparam int CLK_DIV   = 2;
  localparam int MAX_BURST = 16;
  localparam int LEN_W     = $clog2(MAX_BURST + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [6:0]       address;
  logic             rw;
  logic [7:0]       regid;
  logic [LEN_W-1:0] length;
  logic             execute;
  logic [7:0]       wr_data;
  logic             wr_ready;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             busy, done, nack;
  wire              scl_w;
  wire              sda_w;

  pullup (scl_w);
  pullup (sda_w);

  always #5 clk = ~clk;

  i2c_burst_controller #(.CLK_DIV(CLK_DIV), .MAX_BURST(MAX_BURST)) dut (
    .clk_i(clk), .rst_i(rst), .address_i(address), .rw_i(rw), .register_id_i(regid),
    .length_i(length), .execute_i(execute), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .busy_o(busy), .done_o(done),
    .nack_o(nack), .scl_o(scl_w), .sda_io(sda_w)
  );

  int checks = 0;
  int errors = 0;

  // Monitor / slave state (written only by the monitor process)
  int         busy_cnt, done_cnt, wr_cnt, rdv_cnt, widx, nlog, start_cnt, rstart_cnt, stop_cnt;
  int         mack_n, rd_idx, bitn, fbyte, clr_seen;
  logic [7:0] rdv_dat [0:7];
  logic [7:0] blog    [0:7];
  logic       mack    [0:7];
  logic       wr_pend, sl_drive, sl_active, sl_sel, sl_rd, tx_done, sp, dp;
  logic [7:0] sh;
  // Stimulus-owned
  int         clr_tog = 0;
  logic       sl_present;
  logic [7:0] wdat     [0:7];
  logic [7:0] rd_bytes [0:3];

  assign wr_data = wdat[widx[2:0]];
  assign sda_w   = sl_drive ? 1'b0 : 1'bz;

  function automatic logic tx_active();
    return sl_sel && sl_rd && (fbyte >= 1) && !tx_done;
  endfunction

  // Bus monitor plus slave model at 0x78, sampled on the falling clock edge.
  initial begin
    logic s, d;
    busy_cnt = 0; done_cnt = 0; wr_cnt = 0; rdv_cnt = 0; widx = 0; nlog = 0;
    start_cnt = 0; rstart_cnt = 0; stop_cnt = 0; mack_n = 0; rd_idx = 0; bitn = 0;
    fbyte = 0; clr_seen = 0; wr_pend = 0; sl_drive = 0; sl_active = 0; sl_sel = 0;
    sl_rd = 0; tx_done = 0; sp = 1; dp = 1; sh = 0;
    forever begin
      @(negedge clk);
      if (clr_seen != clr_tog) begin
        clr_seen = clr_tog;
        busy_cnt = 0; done_cnt = 0; wr_cnt = 0; rdv_cnt = 0; widx = 0; wr_pend = 0;
        nlog = 0; start_cnt = 0; rstart_cnt = 0; stop_cnt = 0; mack_n = 0; rd_idx = 0;
        sl_active = 0;
      end
      if (wr_pend) widx++;
      wr_pend = wr_ready;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (wr_ready) wr_cnt++;
      if (rd_valid) begin rdv_dat[rdv_cnt[2:0]] = rd_data; rdv_cnt++; end

      s = (scl_w !== 1'b0);
      d = (sda_w !== 1'b0);
      if (sp && s && dp && !d) begin
        if (sl_active) rstart_cnt++; else start_cnt++;
        sl_active = 1; bitn = 0; fbyte = 0; tx_done = 0; sl_sel = 0; sl_drive = 0;
      end else if (sp && s && !dp && d) begin
        stop_cnt++; sl_active = 0; sl_drive = 0;
      end else if (!sp && s) begin
        if (bitn < 8) begin
          sh = {sh[6:0], d};
          bitn++;
          if (bitn == 8) begin
            if (fbyte == 0) begin
              sl_rd  = sh[0];
              sl_sel = sl_present && (sh[7:1] == 7'h78);
            end
            if (!tx_active()) begin blog[nlog[2:0]] = sh; nlog++; end
          end
        end else begin
          if (tx_active()) begin
            mack[mack_n[2:0]] = d; mack_n++; rd_idx++;
            if (d) tx_done = 1;
          end
          fbyte++;
          bitn = 0;
        end
      end else if (sp && !s) begin
        if (bitn == 8) sl_drive = sl_sel && !tx_active();
        else           sl_drive = tx_active() && !rd_bytes[rd_idx[1:0]][7-bitn];
      end
      sp = s;
      dp = d;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_txn(input logic [6:0] a, input logic r, input logic [7:0] rg, input int len);
    @(negedge clk);
    clr_tog++;
    address = a; rw = r; regid = rg; length = LEN_W'(len);
    execute = 1'b1;
    @(negedge clk);
    execute = 1'b0;
  endtask

  // Waits for done_o; optionally re-asserts execute_i (with another address) mid-burst.
  task automatic wait_done(input int budget, input int poke_at);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
      if (n == poke_at) begin execute = 1'b1; address = 7'h11; end
      else if (n == poke_at + 1) begin execute = 1'b0; address = 7'h78; end
    end
    chk("done_seen", 32'(done_cnt != 0), 32'd1);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; execute = 1'b0; address = 7'h78; rw = 1'b0; regid = 8'h0F; length = '0;
    sl_present = 1'b1;
    wdat[0] = 8'h55; wdat[1] = 8'hAA;
    for (int i = 2; i < 8; i++) wdat[i] = 8'h00;
    rd_bytes[0] = 8'h11; rd_bytes[1] = 8'h22; rd_bytes[2] = 8'h33; rd_bytes[3] = 8'h44;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_nack", 32'(nack), 0);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_scl", 32'(scl_w), 1);
    chk("rst_sda", 32'(sda_w), 1);
    rst = 1'b0;
    @(negedge clk);

    // Write burst of 2 with a stray execute mid-burst
    start_txn(7'h78, 1'b0, 8'h0F, 2);
    wait_done(1000, 50);
    chk("w_nlog", nlog, 4);
    chk("w_b0", 32'(blog[0]), 32'hF0);
    chk("w_b1", 32'(blog[1]), 32'h0F);
    chk("w_b2", 32'(blog[2]), 32'h55);
    chk("w_b3", 32'(blog[3]), 32'hAA);
    chk("w_wr_ready", wr_cnt, 2);
    chk("w_busy", busy_cnt, 304);
    chk("w_done", done_cnt, 1);
    chk("w_nack", 32'(nack), 0);
    chk("w_start", start_cnt, 1);
    chk("w_rstart", rstart_cnt, 0);
    chk("w_stop", stop_cnt, 1);
    chk("w_idle_after", 32'(busy), 0);

    // Read burst of 3
    start_txn(7'h78, 1'b1, 8'h0F, 3);
    wait_done(1000, -10);
    chk("r_nlog", nlog, 3);
    chk("r_b0", 32'(blog[0]), 32'hF0);
    chk("r_b1", 32'(blog[1]), 32'h0F);
    chk("r_b2", 32'(blog[2]), 32'hF1);
    chk("r_rstart", rstart_cnt, 1);
    chk("r_valid_cnt", rdv_cnt, 3);
    chk("r_d0", 32'(rdv_dat[0]), 32'h11);
    chk("r_d1", 32'(rdv_dat[1]), 32'h22);
    chk("r_d2", 32'(rdv_dat[2]), 32'h33);
    chk("r_mack_n", mack_n, 3);
    chk("r_mack0", 32'(mack[0]), 0);
    chk("r_mack1", 32'(mack[1]), 0);
    chk("r_mack2", 32'(mack[2]), 1);
    chk("r_busy", busy_cnt, 456);
    chk("r_rd_hold", 32'(rd_data), 32'h33);
    chk("r_nack", 32'(nack), 0);

    // Address NACK on a write of 4
    sl_present = 1'b0;
    start_txn(7'h78, 1'b0, 8'h0F, 4);
    wait_done(1000, -10);
    chk("n_nack", 32'(nack), 1);
    chk("n_wr_ready", wr_cnt, 0);
    chk("n_busy", busy_cnt, 88);
    chk("n_done", done_cnt, 1);
    chk("n_nlog", nlog, 1);
    chk("n_stop", stop_cnt, 1);
    sl_present = 1'b1;

    // Register-pointer-only read (length 0); accepting it clears nack_o
    start_txn(7'h78, 1'b1, 8'h06, 0);
    chk("z_nack_cleared", 32'(nack), 0);
    wait_done(1000, -10);
    chk("z_nlog", nlog, 2);
    chk("z_b0", 32'(blog[0]), 32'hF0);
    chk("z_b1", 32'(blog[1]), 32'h06);
    chk("z_rstart", rstart_cnt, 0);
    chk("z_rd_valid", rdv_cnt, 0);
    chk("z_busy", busy_cnt, 160);
    chk("z_done", done_cnt, 1);

    // Reset during WDATA aborts at once
    start_txn(7'h78, 1'b0, 8'h0F, 2);
    begin
      int n = 0;
      while (wr_cnt == 0 && n < 400) begin @(negedge clk); n++; end
      chk("a_reached_wdata", 32'(wr_cnt), 1);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("a_scl_released", 32'(scl_w), 1);
    chk("a_sda_released", 32'(sda_w), 1);
    chk("a_busy", 32'(busy), 0);
    repeat (20) @(negedge clk);
    chk("a_no_done", done_cnt, 0);

    // Normal write after the abort
    wdat[0] = 8'h3C;
    start_txn(7'h78, 1'b0, 8'h0F, 1);
    wait_done(1000, -10);
    chk("p_nlog", nlog, 3);
    chk("p_b2", 32'(blog[2]), 32'h3C);
    chk("p_busy", busy_cnt, 232);
    chk("p_done", done_cnt, 1);
    chk("p_nack", 32'(nack), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
